// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and FIFO entry type for the register writeback path
package wb_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries with wrap-bit pointers
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  wb_entry_t              din,
   output wb_entry_t              dout,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   wb_entry_t mem [DEPTH];
   logic [AW:0] wptr, rptr;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         wptr <= wptr + CW'(push);
         rptr <= rptr + CW'(pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wptr[AW-1:0]] <= din;
   assign dout  = mem[rptr[AW-1:0]];
   assign count = wptr - rptr;
endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: arbitrates ALU/mem results into the register file write port with a pending scoreboard
// Optional WB_BYPASS_EN: an empty FIFO lets a result load the output register directly.
module reg_writeback_ctrl #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alu_valid,
   output logic                        alu_ready,
   input  logic [ADDR_W-1:0]           alu_reg,
   input  logic [DATA_W-1:0]           alu_data,
   input  logic                        mem_valid,
   output logic                        mem_ready,
   input  logic [ADDR_W-1:0]           mem_reg,
   input  logic [DATA_W-1:0]           mem_data,
   input  logic                        issue_valid,
   input  logic [ADDR_W-1:0]           issue_reg,
   output logic [31:0]                 pending,
   output logic                        reg_write,
   output logic [ADDR_W-1:0]           write_reg,
   output logic [DATA_W-1:0]           write_data,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   import wb_pkg::*;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   wb_entry_t in_e, head;
   logic full, empty, acc, push, pop, byp;
   logic [NUM_REGS-1:0] set_m, clr_m;
   assign full      = fifo_count == FULL;
   assign empty     = fifo_count == '0;
   assign mem_ready = !full;
   assign alu_ready = !full && !mem_valid;
   assign acc       = (mem_valid || alu_valid) && !full;
   assign in_e      = mem_valid ? '{addr: mem_reg, data: mem_data} : '{addr: alu_reg, data: alu_data};
`ifdef WB_BYPASS_EN
   assign byp = acc && in_e.addr != '0 && empty;
`else
   assign byp = 1'b0;
`endif
   assign push  = acc && in_e.addr != '0 && !byp;
   assign pop   = !empty;
   assign set_m = issue_valid ? NUM_REGS'(1) << issue_reg : '0;
   assign clr_m = reg_write ? NUM_REGS'(1) << write_reg : '0;
   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (in_e),
      .dout  (head),
      .count (fifo_count)
   );
   // set is ORed after clear so a same-edge issue keeps the bit; x0 never pends
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pending    <= '0;
         reg_write  <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
      end else begin
         pending   <= (pending & ~clr_m | set_m) & ~NUM_REGS'(1);
         reg_write <= pop || byp;
         if (pop) {write_reg, write_data} <= head;
         else if (byp) {write_reg, write_data} <= in_e;
      end
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: queue-model checked random and directed test of reg_writeback_ctrl
module tb_reg_writeback_ctrl;
   import wb_pkg::*;
   localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
   localparam int L   = 0;
`else
   localparam bit BYP = 1'b0;
   localparam int L   = 1;
`endif
   logic clk = 0, rst = 1;
   logic alu_valid = 0, mem_valid = 0, issue_valid = 0;
   logic [4:0] alu_reg = 0, mem_reg = 0, issue_reg = 0;
   logic [31:0] alu_data = 0, mem_data = 0;
   logic alu_ready, mem_ready, reg_write;
   logic [31:0] pending, write_data;
   logic [4:0] write_reg;
   logic [2:0] fifo_count;
   int total = 0, bad = 0;

   reg_writeback_ctrl #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
      .issue_valid(issue_valid), .issue_reg(issue_reg), .pending(pending),
      .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   wb_entry_t q[$];
   wb_entry_t m_e;
   bit m_rw, m_full, m_acc;
   logic [4:0] m_wr;
   logic [31:0] m_wd, m_pend;

   // reference: an ordered queue drained one entry per edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_rw = 0; m_wr = 0; m_wd = 0; m_pend = 0;
      end else begin
         m_full = q.size() == DEPTH;
         m_acc = (mem_valid || alu_valid) && !m_full;
         m_e = mem_valid ? '{addr: mem_reg, data: mem_data} : '{addr: alu_reg, data: alu_data};
         if (m_acc && m_e.addr == 0) m_acc = 0;
         if (m_rw) m_pend[m_wr] = 1'b0;
         if (issue_valid && issue_reg != 0) m_pend[issue_reg] = 1'b1;
         if (q.size() > 0) begin
            m_rw = 1; m_wr = q[0].addr; m_wd = q[0].data;
            void'(q.pop_front());
         end else if (BYP && m_acc) begin
            m_rw = 1; m_wr = m_e.addr; m_wd = m_e.data;
            m_acc = 0;
         end else m_rw = 0;
         if (m_acc) q.push_back(m_e);
      end
   end

   task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("mem_ready", mem_ready, q.size() != DEPTH);
      chk("alu_ready", alu_ready, q.size() != DEPTH && !mem_valid);
      chk("fifo_count", fifo_count, q.size());
      chk("reg_write", reg_write, m_rw);
      chk("write_reg", write_reg, m_wr);
      chk("write_data", write_data, m_wd);
      chk("pending", pending, m_pend);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) tick();
      rst = 0;
      tick();
      chk("rst_rw", reg_write, 0);
      chk("rst_cnt", fifo_count, 0);
      chk("rst_pend", pending, 0);
      chk("rst_wdata", write_data, 0);
      chk("rst_rdy", {alu_ready, mem_ready}, 2'b11);
      // single ALU write
      alu_valid = 1; alu_reg = 5; alu_data = 32'hDEADBEEF;
      tick();
      alu_valid = 0;
      repeat (L) tick();
      chk("single_rw", reg_write, 1);
      chk("single_reg", write_reg, 5);
      chk("single_data", write_data, 32'hDEADBEEF);
      tick();
      chk("single_rw_off", reg_write, 0);
      // scoreboard set/clear
      issue_valid = 1; issue_reg = 7;
      tick();
      issue_valid = 0;
      chk("sb_set7", pending[7], 1);
      repeat (2) tick();
      alu_valid = 1; alu_reg = 7; alu_data = 32'h77;
      tick();
      alu_valid = 0;
      repeat (L) tick();
      chk("sb_hold7", pending[7], 1);
      tick();
      chk("sb_clr7", pending[7], 0);
      issue_valid = 1; issue_reg = 0;
      tick();
      issue_valid = 0;
      chk("sb_reg0", pending, 0);
      // priority
      mem_valid = 1; mem_reg = 3; mem_data = 32'h33;
      alu_valid = 1; alu_reg = 4; alu_data = 32'h44;
      #1;
      chk("prio_rdy", {mem_ready, alu_ready}, 2'b10);
      tick();
      mem_valid = 0;
      tick();
      alu_valid = 0;
      repeat (L) tick();
      chk("prio_last_reg", write_reg, 4);
      chk("prio_last_data", write_data, 32'h44);
      repeat (2) tick();
      // destination 0
      mem_valid = 1; mem_reg = 0; mem_data = 32'h1234;
      #1;
      chk("d0_ready", mem_ready, 1);
      tick();
      mem_valid = 0;
      chk("d0_cnt", fifo_count, 0);
      chk("d0_rw", reg_write, 0);
      tick();
      chk("d0_rw2", reg_write, 0);
      // same-edge set and clear
      alu_valid = 1; alu_reg = 9; alu_data = 32'h99;
      tick();
      alu_valid = 0;
      repeat (L) tick();
      chk("col_rw", {reg_write, write_reg}, {1'b1, 5'd9});
      issue_valid = 1; issue_reg = 9;
      tick();
      issue_valid = 0;
      chk("col_pend9", pending[9], 1);
      // six back-to-back
      for (int i = 0; i < 6; i++) begin
         mem_valid = 1; mem_reg = 5'(10 + i); mem_data = 32'(i);
         tick();
      end
      mem_valid = 0;
      repeat (L) tick();
      chk("b2b_last_reg", write_reg, 15);
      chk("b2b_last_data", write_data, 5);
      // reset mid-stream
      for (int i = 0; i < 3; i++) begin
         mem_valid = 1; mem_reg = 5'(20 + i); mem_data = 32'(100 + i);
         issue_valid = 1; issue_reg = 5'(20 + i);
         tick();
      end
      issue_valid = 0;
      #1 rst = 1;
      #1;
      chk("mrst_rw", reg_write, 0);
      chk("mrst_cnt", fifo_count, 0);
      chk("mrst_pend", pending, 0);
      rst = 0; mem_valid = 0;
      tick();
      chk("mrst_rw2", reg_write, 0);
      tick();
      chk("mrst_rw3", reg_write, 0);
      // random traffic
      for (int c = 0; c < 500; c++) begin
         mem_valid = $urandom_range(0, 2) == 0;
         alu_valid = $urandom_range(0, 1) == 1;
         mem_reg = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom);
         alu_reg = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom);
         mem_data = $urandom;
         alu_data = $urandom;
         issue_valid = $urandom_range(0, 1) == 1;
         issue_reg = 5'($urandom);
         tick();
      end
      mem_valid = 0; alu_valid = 0; issue_valid = 0;
      repeat (4) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
